register_file_scoreboard: RTL and testbench

REGISTER_FILE_SCOREBOARD -- requirements
Module: register_file_scoreboard

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_read_port.sv | 38 +++
 rtl/register_file_scoreboard.sv | 99 +++++++++
 tb/tb_register_file_scoreboard.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and address type for the register file scoreboard.
package regfile_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int NUM_REGISTERS = 32;
    localparam int ADDR_WIDTH    = $clog2(NUM_REGISTERS);

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: register select, writeback forwarding and busy lookup.
module regfile_read_port #(
    parameter int DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
    parameter int NUM_REGISTERS = regfile_pkg::NUM_REGISTERS,
    parameter int BYPASS        = 1,
    localparam int AW           = $clog2(NUM_REGISTERS)
) (
    input  logic [AW-1:0]                             addr,
    input  logic [NUM_REGISTERS-1:0][DATA_WIDTH-1:0]  regs,
    input  logic [NUM_REGISTERS-1:0]                  busy_bits,
    input  logic                                      wb_valid,
    input  logic [AW-1:0]                             wb_addr,
    input  logic [DATA_WIDTH-1:0]                     wb_data,
    output logic [DATA_WIDTH-1:0]                     data,
    output logic                                      busy
);
    import regfile_pkg::*;

    logic addr_zero;
    logic fwd_hit;

    assign addr_zero = (addr == '0);
    // A writeback landing this cycle makes the register both valid and the freshest value.
    assign fwd_hit   = (BYPASS != 0) && wb_valid && (wb_addr == addr) && !addr_zero;

    always_comb begin
        data = regs[addr];
        busy = busy_bits[addr];
        if (addr_zero) begin
            data = '0;
            busy = 1'b0;
        end else if (fwd_hit) begin
            data = wb_data;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/register_file_scoreboard.sv
// Register file with per-register pending-write scoreboard, multi-port reads and writeback forwarding.
module register_file_scoreboard #(
    parameter int DATA_WIDTH     = regfile_pkg::DATA_WIDTH,
    parameter int NUM_REGISTERS  = regfile_pkg::NUM_REGISTERS,
    parameter int NUM_READ_PORTS = 2,
    parameter int BYPASS         = 1,
    localparam int AW            = $clog2(NUM_REGISTERS),
    localparam int CW            = $clog2(NUM_REGISTERS + 1)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_READ_PORTS-1:0][AW-1:0]          rd_addr,
    output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]  rd_data,
    output logic [NUM_READ_PORTS-1:0]                  rd_busy,
    input  logic                                       issue_valid,
    input  logic [AW-1:0]                              issue_addr,
    output logic                                       issue_ready,
    input  logic                                       wb_valid,
    input  logic [AW-1:0]                              wb_addr,
    input  logic [DATA_WIDTH-1:0]                      wb_data,
    output logic [CW-1:0]                              pending_count,
    output logic                                       err_wb_unexpected
);
    import regfile_pkg::*;

    logic [NUM_REGISTERS-1:0][DATA_WIDTH-1:0] data_reg;
    logic [NUM_REGISTERS-1:0][DATA_WIDTH-1:0] data_next;
    logic [NUM_REGISTERS-1:0]                 busy_reg;
    logic [NUM_REGISTERS-1:0]                 busy_next;
    logic [CW-1:0]                            count_reg;
    logic                                     err_reg;

    logic wb_hit;
    logic issue_hit;
    logic count_inc;
    logic count_dec;

    assign wb_hit      = wb_valid && (wb_addr != '0);
    assign issue_ready = (issue_addr == '0) || !busy_reg[issue_addr] ||
                         (wb_valid && (wb_addr == issue_addr));
    assign issue_hit   = issue_valid && issue_ready && (issue_addr != '0);

    // A same-register issue+writeback keeps the bit set, so it neither adds nor removes a pending entry.
    assign count_inc = issue_hit && !busy_reg[issue_addr];
    assign count_dec = wb_hit && busy_reg[wb_addr] && !(issue_hit && (issue_addr == wb_addr));

    assign data_next[0] = '0;
    assign busy_next[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGISTERS; gi++) begin : g_reg
            logic set_hit;
            logic clr_hit;
            assign set_hit       = issue_hit && (issue_addr == AW'(gi));
            assign clr_hit       = wb_hit && (wb_addr == AW'(gi));
            assign data_next[gi] = clr_hit ? wb_data : data_reg[gi];
            assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_reg  <= '0;
            busy_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            data_reg  <= data_next;
            busy_reg  <= busy_next;
            count_reg <= count_reg + CW'(count_inc) - CW'(count_dec);
            if (wb_hit && !busy_reg[wb_addr]) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign pending_count     = count_reg;
    assign err_wb_unexpected = err_reg;

    generate
        for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_port
            regfile_read_port #(
                .DATA_WIDTH    (DATA_WIDTH),
                .NUM_REGISTERS (NUM_REGISTERS),
                .BYPASS        (BYPASS)
            ) u_port (
                .addr      (rd_addr[gi]),
                .regs      (data_reg),
                .busy_bits (busy_reg),
                .wb_valid  (wb_valid),
                .wb_addr   (wb_addr),
                .wb_data   (wb_data),
                .data      (rd_data[gi]),
                .busy      (rd_busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard at default parameters.
module tb_register_file_scoreboard;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0][4:0]   rd_addr;
    logic [1:0][31:0]  rd_data;
    logic [1:0]        rd_busy;
    logic              issue_valid;
    logic [4:0]        issue_addr;
    logic              issue_ready;
    logic              wb_valid;
    logic [4:0]        wb_addr;
    logic [31:0]       wb_data;
    logic [5:0]        pending_count;
    logic              err_wb_unexpected;

    int nvec  = 0;
    int nfail = 0;

    register_file_scoreboard dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .rd_busy           (rd_busy),
        .issue_valid       (issue_valid),
        .issue_addr        (issue_addr),
        .issue_ready       (issue_ready),
        .wb_valid          (wb_valid),
        .wb_addr           (wb_addr),
        .wb_data           (wb_data),
        .pending_count     (pending_count),
        .err_wb_unexpected (err_wb_unexpected)
    );

    always #5 clk = ~clk;

    // Advance one edge, then move away from it before driving or sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_addr  = '0;
        wb_valid    = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        rd_addr = '0;
        rst_n   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        issue_addr = 5'd5;
        #1;
        for (int r = 0; r < 32; r++) begin
            reg_addr_t a;
            a = reg_addr_t'(r);
            rd_addr[0] = a;
            rd_addr[1] = 5'd31 - a;
            #1;
            nvec++;
            if (rd_data[0] !== 32'h0 || rd_data[1] !== 32'h0 || rd_busy !== 2'b00) begin
                nfail++;
                $display("FAIL reset_read r%0d: got %h/%h busy %b expected 0/0 busy 00",
                         r, rd_data[0], rd_data[1], rd_busy);
            end
        end
        nvec++;
        if (pending_count !== 6'd0) begin
            nfail++;
            $display("FAIL reset_count: got %0d expected 0", pending_count);
        end
        chk_bit("reset_issue_ready", issue_ready, 1'b1);
        chk_bit("reset_err", err_wb_unexpected, 1'b0);
        $display("test_reset: 32 registers read on both ports");
    endtask

    task automatic test_issue();
        issue_valid = 1'b1;
        issue_addr  = 5'd5;
        #1;
        chk_bit("issue_r5_ready", issue_ready, 1'b1);
        step();
        issue_valid = 1'b0;
        rd_addr[0]  = 5'd5;
        rd_addr[1]  = 5'd6;
        #1;
        chk_bit("issue_r5_busy", rd_busy[0], 1'b1);
        chk_bit("issue_r6_not_busy", rd_busy[1], 1'b0);
        nvec++;
        if (pending_count !== 6'd1) begin
            nfail++;
            $display("FAIL issue_count: got %0d expected 1", pending_count);
        end
        issue_valid = 1'b1;
        #1;
        chk_bit("reissue_r5_ready", issue_ready, 1'b0);
        issue_addr = 5'd0;
        #1;
        chk_bit("issue_r0_ready", issue_ready, 1'b1);
        issue_valid = 1'b0;
        $display("test_issue: r5 marked pending, re-issue stalled");
    endtask

    task automatic test_bypass();
        wb_valid   = 1'b1;
        wb_addr    = 5'd5;
        wb_data    = 32'hDEADBEEF;
        rd_addr[0] = 5'd5;
        rd_addr[1] = 5'd6;
        #1;
        nvec++;
        if (rd_data[0] !== 32'hDEADBEEF) begin
            nfail++;
            $display("FAIL bypass_data: got %h expected deadbeef", rd_data[0]);
        end
        chk_bit("bypass_busy", rd_busy[0], 1'b0);
        nvec++;
        if (rd_data[1] !== 32'h0) begin
            nfail++;
            $display("FAIL bypass_other_port: got %h expected 0", rd_data[1]);
        end
        step();
        idle();
        #1;
        nvec++;
        if (rd_data[0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0 || pending_count !== 6'd0) begin
            nfail++;
            $display("FAIL wb_commit: got %h busy %b count %0d expected deadbeef busy 0 count 0",
                     rd_data[0], rd_busy[0], pending_count);
        end
        chk_bit("wb_expected_no_err", err_wb_unexpected, 1'b0);
        $display("test_bypass: r5 writeback forwarded and committed");
    endtask

    task automatic test_set_wins();
        issue_valid = 1'b1;
        issue_addr  = 5'd7;
        step();
        wb_valid = 1'b1;
        wb_addr  = 5'd7;
        wb_data  = 32'h1234;
        #1;
        chk_bit("set_wins_ready", issue_ready, 1'b1);
        step();
        idle();
        rd_addr[1] = 5'd7;
        #1;
        nvec++;
        if (rd_data[1] !== 32'h1234 || rd_busy[1] !== 1'b1 || pending_count !== 6'd1) begin
            nfail++;
            $display("FAIL set_wins: got %h busy %b count %0d expected 1234 busy 1 count 1",
                     rd_data[1], rd_busy[1], pending_count);
        end
        // Retire r7 while issuing r10: one clear and one set in the same cycle.
        issue_valid = 1'b1;
        issue_addr  = 5'd10;
        wb_valid    = 1'b1;
        wb_addr     = 5'd7;
        wb_data     = 32'hA5A5_0007;
        step();
        idle();
        rd_addr[0] = 5'd10;
        #1;
        nvec++;
        if (rd_busy !== 2'b01 || rd_data[1] !== 32'hA5A5_0007 || pending_count !== 6'd1) begin
            nfail++;
            $display("FAIL back_to_back: got busy %b r7 %h count %0d expected busy 01 r7 a5a50007 count 1",
                     rd_busy, rd_data[1], pending_count);
        end
        chk_bit("set_wins_no_err", err_wb_unexpected, 1'b0);
        $display("test_set_wins: r7 issue+wb same cycle, r10 set with r7 clear");
    endtask

    task automatic test_unexpected_wb();
        wb_valid = 1'b1;
        wb_addr  = 5'd9;
        wb_data  = 32'h55;
        step();
        idle();
        rd_addr[0] = 5'd9;
        #1;
        chk_bit("err_set", err_wb_unexpected, 1'b1);
        nvec++;
        if (rd_data[0] !== 32'h55) begin
            nfail++;
            $display("FAIL unexpected_wb_data: got %h expected 55", rd_data[0]);
        end
        step();
        step();
        chk_bit("err_sticky", err_wb_unexpected, 1'b1);
        wb_valid    = 1'b1;
        wb_addr     = 5'd0;
        wb_data     = 32'hFF;
        issue_valid = 1'b1;
        issue_addr  = 5'd0;
        rd_addr[1]  = 5'd0;
        #1;
        nvec++;
        if (rd_data[1] !== 32'h0 || rd_busy[1] !== 1'b0) begin
            nfail++;
            $display("FAIL r0_bypass: got %h busy %b expected 0 busy 0", rd_data[1], rd_busy[1]);
        end
        step();
        idle();
        #1;
        nvec++;
        if (rd_data[1] !== 32'h0 || rd_busy[1] !== 1'b0 || pending_count !== 6'd1) begin
            nfail++;
            $display("FAIL r0_write: got %h busy %b count %0d expected 0 busy 0 count 1",
                     rd_data[1], rd_busy[1], pending_count);
        end
        $display("test_unexpected_wb: r9 unexpected writeback flagged, r0 stays zero");
    endtask

    task automatic test_midop_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd3;
        step();
        issue_addr  = 5'd4;
        step();
        idle();
        #1;
        nvec++;
        if (pending_count !== 6'd3) begin
            nfail++;
            $display("FAIL pre_reset_count: got %0d expected 3", pending_count);
        end
        rst_n       = 1'b0;
        issue_valid = 1'b1;
        issue_addr  = 5'd11;
        wb_valid    = 1'b1;
        wb_addr     = 5'd12;
        wb_data     = 32'h77;
        step();
        rst_n = 1'b1;
        idle();
        rd_addr[0] = 5'd3;
        rd_addr[1] = 5'd4;
        #1;
        nvec++;
        if (rd_busy !== 2'b00 || pending_count !== 6'd0 || err_wb_unexpected !== 1'b0) begin
            nfail++;
            $display("FAIL midop_reset: got busy %b count %0d err %b expected 00 0 0",
                     rd_busy, pending_count, err_wb_unexpected);
        end
        rd_addr[0] = 5'd9;
        rd_addr[1] = 5'd11;
        #1;
        nvec++;
        if (rd_data[0] !== 32'h0 || rd_busy[1] !== 1'b0) begin
            nfail++;
            $display("FAIL reset_discard: got r9 %h r11 busy %b expected 0 busy 0",
                     rd_data[0], rd_busy[1]);
        end
        rd_addr[0] = 5'd12;
        rd_addr[1] = 5'd5;
        issue_addr = 5'd3;
        #1;
        nvec++;
        if (rd_data !== 64'h0 || issue_ready !== 1'b1) begin
            nfail++;
            $display("FAIL reset_data: got r12 %h r5 %h ready %b expected 0 0 1",
                     rd_data[0], rd_data[1], issue_ready);
        end
        $display("test_midop_reset: pending r3/r4/r10 dropped by reset");
    endtask

    initial begin
        test_reset();
        test_issue();
        test_bypass();
        test_set_wins();
        test_unexpected_wb();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
